// File: rtl/ls_exec_unit.sv
// Load/store execution stage: computes the effective address, runs one access over the
// memory-controller handshake, and broadcasts the result to the reorder buffer.
module ls_exec_unit #(
    parameter int unsigned     OP_W    = 6,
    parameter int unsigned     ROB_W   = 4,
    parameter logic [OP_W-1:0] OP_BASE = 6'd10,
    parameter logic [1:0]      IO_MASK = 2'b11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             LSB_input_valid,
    input  logic [OP_W-1:0]  LSB_OP_ID,
    input  logic [31:0]      LSB_inst_pc,
    input  logic [31:0]      LSB_reg_rs1,
    input  logic [31:0]      LSB_reg_rs2,
    input  logic [31:0]      LSB_imm,
    input  logic [ROB_W-1:0] LSB_ROB_id,
    output logic             LSB_ready,
    input  logic [ROB_W-1:0] ROB_head_id,
    input  logic             ROB_roll_back_flag,
    output logic             MC_req_valid,
    output logic             MC_is_write,
    output logic [31:0]      MC_addr,
    output logic [31:0]      MC_wdata,
    output logic [1:0]       MC_size,
    input  logic             MC_done,
    input  logic [31:0]      MC_rdata,
    output logic             ROB_output_valid,
    output logic [ROB_W-1:0] ROB_output_id,
    output logic [31:0]      ROB_output_value
);

    typedef enum logic [1:0] {IDLE, WAIT_HEAD, MEM, BCAST} state_t;

    state_t state;
    logic   squash;
    logic   ld_signed;

    logic [OP_W-1:0] op_idx;
    logic            op_in_win;
    logic            dec_store;
    logic            dec_signed;
    logic [1:0]      dec_size;
    logic [31:0]     eff_addr;
    logic            need_head;
    logic            unused_pc;

    // Byte/half results come back zero-filled; sign-extend only for LB/LH.
    function automatic logic [31:0] load_extract(input logic [31:0] rd,
                                                 input logic [1:0]  sz,
                                                 input logic        sgn);
        logic [31:0] res;
        case (sz)
            2'd0:    res = {{24{sgn & rd[7]}}, rd[7:0]};
            2'd1:    res = {{16{sgn & rd[15]}}, rd[15:0]};
            default: res = rd;
        endcase
        return res;
    endfunction

    assign unused_pc = ^LSB_inst_pc;

    assign op_idx    = LSB_OP_ID - OP_BASE;
    assign op_in_win = (op_idx[OP_W-1:3] == '0);
    assign eff_addr  = LSB_reg_rs1 + LSB_imm;

    always_comb begin
        dec_store  = 1'b0;
        dec_signed = 1'b0;
        dec_size   = 2'd2;
        if (op_in_win) begin
            case (op_idx[2:0])
                3'd0:    begin dec_size = 2'd0; dec_signed = 1'b1; end
                3'd1:    begin dec_size = 2'd1; dec_signed = 1'b1; end
                3'd2:    dec_size = 2'd2;
                3'd3:    dec_size = 2'd0;
                3'd4:    dec_size = 2'd1;
                3'd5:    begin dec_size = 2'd0; dec_store = 1'b1; end
                3'd6:    begin dec_size = 2'd1; dec_store = 1'b1; end
                default: begin dec_size = 2'd2; dec_store = 1'b1; end
            endcase
        end
    end

    // Stores and IO-space loads must not run speculatively.
    assign need_head = dec_store || (eff_addr[17:16] == IO_MASK);

    assign LSB_ready        = (state == IDLE) && !ROB_roll_back_flag;
    assign ROB_output_valid = (state == BCAST) && !ROB_roll_back_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            squash           <= 1'b0;
            ld_signed        <= 1'b0;
            MC_req_valid     <= 1'b0;
            MC_is_write      <= 1'b0;
            MC_addr          <= '0;
            MC_wdata         <= '0;
            MC_size          <= '0;
            ROB_output_id    <= '0;
            ROB_output_value <= '0;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (LSB_input_valid && LSB_ready) begin
                        MC_addr       <= eff_addr;
                        MC_wdata      <= LSB_reg_rs2;
                        MC_size       <= dec_size;
                        MC_is_write   <= dec_store;
                        ld_signed     <= dec_signed;
                        ROB_output_id <= LSB_ROB_id;
                        if (need_head) begin
                            state <= WAIT_HEAD;
                        end else begin
                            state        <= MEM;
                            MC_req_valid <= 1'b1;
                        end
                    end
                end
                WAIT_HEAD: begin
                    if (ROB_roll_back_flag) begin
                        state <= IDLE;
                    end else if (ROB_head_id == ROB_output_id) begin
                        state        <= MEM;
                        MC_req_valid <= 1'b1;
                    end
                end
                MEM: begin
                    if (MC_done) begin
                        MC_req_valid     <= 1'b0;
                        squash           <= 1'b0;
                        ROB_output_value <= MC_is_write ? 32'd0
                                                        : load_extract(MC_rdata, MC_size, ld_signed);
                        // A rollback seen at any point of the access drops the broadcast.
                        state <= (squash || ROB_roll_back_flag) ? IDLE : BCAST;
                    end else if (ROB_roll_back_flag) begin
                        squash <= 1'b1;
                    end
                end
                BCAST: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ls_exec_unit.sv
// Bench for ls_exec_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ls_exec_unit;

    localparam int              OP_W    = 6;
    localparam int              ROB_W   = 4;
    localparam logic [OP_W-1:0] OP_BASE = 6'd10;

    logic             clk;
    logic             rst;
    logic             rdy;
    logic             LSB_input_valid;
    logic [OP_W-1:0]  LSB_OP_ID;
    logic [31:0]      LSB_inst_pc;
    logic [31:0]      LSB_reg_rs1;
    logic [31:0]      LSB_reg_rs2;
    logic [31:0]      LSB_imm;
    logic [ROB_W-1:0] LSB_ROB_id;
    logic             LSB_ready;
    logic [ROB_W-1:0] ROB_head_id;
    logic             ROB_roll_back_flag;
    logic             MC_req_valid;
    logic             MC_is_write;
    logic [31:0]      MC_addr;
    logic [31:0]      MC_wdata;
    logic [1:0]       MC_size;
    logic             MC_done;
    logic [31:0]      MC_rdata;
    logic             ROB_output_valid;
    logic [ROB_W-1:0] ROB_output_id;
    logic [31:0]      ROB_output_value;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the op in flight: busy from accept until it leaves, req while the MC access runs.
    bit          m_busy, m_req, m_bcast, m_squash, m_write, m_sgn, m_need;
    logic [31:0] m_addr, m_wdata, m_val;
    int          m_size;
    logic [3:0]  m_id;

    int size_tab[8] = '{0, 1, 2, 0, 1, 0, 1, 2};
    bit sgn_tab[8]  = '{1, 1, 0, 0, 0, 0, 0, 0};

    ls_exec_unit #(.OP_W(OP_W), .ROB_W(ROB_W), .OP_BASE(OP_BASE), .IO_MASK(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .LSB_input_valid(LSB_input_valid), .LSB_OP_ID(LSB_OP_ID), .LSB_inst_pc(LSB_inst_pc),
        .LSB_reg_rs1(LSB_reg_rs1), .LSB_reg_rs2(LSB_reg_rs2), .LSB_imm(LSB_imm),
        .LSB_ROB_id(LSB_ROB_id), .LSB_ready(LSB_ready), .ROB_head_id(ROB_head_id),
        .ROB_roll_back_flag(ROB_roll_back_flag), .MC_req_valid(MC_req_valid),
        .MC_is_write(MC_is_write), .MC_addr(MC_addr), .MC_wdata(MC_wdata), .MC_size(MC_size),
        .MC_done(MC_done), .MC_rdata(MC_rdata), .ROB_output_valid(ROB_output_valid),
        .ROB_output_id(ROB_output_id), .ROB_output_value(ROB_output_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int size, input bit sgn);
        longint bits, v;
        if (size == 2) return rd;
        bits = 8 << size;
        v = longint'(rd) % (longint'(1) << bits);
        if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_req = 0; m_bcast = 0; m_squash = 0;
    endtask

    task automatic model_accept();
        int idx;
        idx = int'(LSB_OP_ID) - int'(OP_BASE);
        if (idx < 0 || idx > 7) idx = 2;
        m_size  = size_tab[idx];
        m_sgn   = sgn_tab[idx];
        m_write = (idx >= 5);
        m_addr  = LSB_reg_rs1 + LSB_imm;
        m_wdata = LSB_reg_rs2;
        m_id    = LSB_ROB_id;
        m_need  = m_write || (m_addr[17:16] == 2'b11);
        m_busy  = 1;
        m_req   = !m_need;
    endtask

    task automatic model_update();
        if (!rst) begin
            model_reset();
            return;
        end
        if (!rdy) return;
        if (m_bcast) begin
            m_bcast = 0;
            m_busy  = 0;
        end else if (!m_busy) begin
            if (LSB_input_valid && !ROB_roll_back_flag) model_accept();
        end else if (!m_req) begin
            if (ROB_roll_back_flag) m_busy = 0;
            else if (ROB_head_id == m_id) m_req = 1;
        end else if (MC_done) begin
            m_req = 0;
            m_val = m_write ? 32'd0 : ref_load(MC_rdata, m_size, m_sgn);
            if (m_squash || ROB_roll_back_flag) begin
                m_busy   = 0;
                m_squash = 0;
            end else begin
                m_bcast = 1;
            end
        end else if (ROB_roll_back_flag) begin
            m_squash = 1;
        end
    endtask

    task automatic compare();
        if (!rst) begin
            chk("rst_ready", 32'(LSB_ready), 32'd1);
            chk("rst_req", 32'(MC_req_valid), 32'd0);
            chk("rst_out_vld", 32'(ROB_output_valid), 32'd0);
            chk("rst_addr", MC_addr, 32'd0);
            chk("rst_wdata", MC_wdata, 32'd0);
            chk("rst_size_wr", {29'd0, MC_size, MC_is_write}, 32'd0);
            chk("rst_out_id", 32'(ROB_output_id), 32'd0);
            chk("rst_out_val", ROB_output_value, 32'd0);
        end else begin
            chk("ready", 32'(LSB_ready), 32'(!m_busy && !ROB_roll_back_flag));
            chk("req_valid", 32'(MC_req_valid), 32'(m_req));
            if (m_req) begin
                chk("req_addr", MC_addr, m_addr);
                chk("req_size", 32'(MC_size), 32'(m_size));
                chk("req_write", 32'(MC_is_write), 32'(m_write));
                if (m_write) chk("req_wdata", MC_wdata, m_wdata);
            end
            chk("out_valid", 32'(ROB_output_valid), 32'(m_bcast && !ROB_roll_back_flag));
            if (m_bcast && !ROB_roll_back_flag) begin
                chk("out_id", 32'(ROB_output_id), 32'(m_id));
                chk("out_value", ROB_output_value, m_val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drive_op(input int op, input logic [31:0] rs1, input logic [31:0] imm,
                            input logic [31:0] rs2, input logic [3:0] id);
        LSB_input_valid = 1;
        LSB_OP_ID       = 6'(op);
        LSB_reg_rs1     = rs1;
        LSB_imm         = imm;
        LSB_reg_rs2     = rs2;
        LSB_ROB_id      = id;
        LSB_inst_pc     = $urandom;
    endtask

    initial begin
        rst = 0; rdy = 1; LSB_input_valid = 0; LSB_OP_ID = '0; LSB_inst_pc = '0;
        LSB_reg_rs1 = '0; LSB_reg_rs2 = '0; LSB_imm = '0; LSB_ROB_id = '0;
        ROB_head_id = '0; ROB_roll_back_flag = 0; MC_done = 0; MC_rdata = '0;
        model_reset();
        tick(); tick();
        rst = 1;
        tick();

        // LW 0x100+4
        drive_op(OP_BASE + 2, 32'h100, 32'h4, 32'h0, 4'd2);
        tick();
        LSB_input_valid = 0;
        chk("lw_req", 32'(MC_req_valid), 32'd1);
        chk("lw_addr", MC_addr, 32'h104);
        chk("lw_size", 32'(MC_size), 32'd2);
        chk("lw_write", 32'(MC_is_write), 32'd0);
        tick(); tick();
        MC_done = 1; MC_rdata = 32'hDEADBEEF;
        tick();
        MC_done = 0;
        chk("lw_out_vld", 32'(ROB_output_valid), 32'd1);
        chk("lw_out_val", ROB_output_value, 32'hDEADBEEF);
        chk("lw_out_id", 32'(ROB_output_id), 32'd2);
        tick();
        chk("lw_out_once", 32'(ROB_output_valid), 32'd0);
        chk("lw_ready_again", 32'(LSB_ready), 32'd1);

        // LB then LBU on 0x80
        for (int k = 0; k < 2; k++) begin
            drive_op(OP_BASE + (k == 0 ? 0 : 3), 32'h40, 32'h0, 32'h0, 4'd3);
            tick();
            LSB_input_valid = 0;
            MC_done = 1; MC_rdata = 32'h00000080;
            tick();
            MC_done = 0;
            chk(k == 0 ? "lb_val" : "lbu_val", ROB_output_value,
                k == 0 ? 32'hFFFFFF80 : 32'h00000080);
            tick();
        end

        // SH waits for head
        ROB_head_id = 4'd3;
        drive_op(OP_BASE + 6, 32'h200, 32'h0, 32'h1234ABCD, 4'd5);
        tick();
        LSB_input_valid = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sh_wait_head", 32'(MC_req_valid), 32'd0);
        end
        ROB_head_id = 4'd5;
        tick();
        chk("sh_req", 32'(MC_req_valid), 32'd1);
        chk("sh_wdata", MC_wdata, 32'h1234ABCD);
        chk("sh_size", 32'(MC_size), 32'd1);
        chk("sh_write", 32'(MC_is_write), 32'd1);
        MC_done = 1; MC_rdata = 32'hFFFFFFFF;
        tick();
        MC_done = 0;
        chk("sh_out_vld", 32'(ROB_output_valid), 32'd1);
        chk("sh_out_val", ROB_output_value, 32'd0);
        chk("sh_out_id", 32'(ROB_output_id), 32'd5);
        tick();

        // IO load, head mismatch, then rollback
        ROB_head_id = 4'd1;
        drive_op(OP_BASE + 2, 32'h00030000, 32'h4, 32'h0, 4'd7);
        tick();
        LSB_input_valid = 0;
        tick(); tick();
        chk("io_no_req", 32'(MC_req_valid), 32'd0);
        ROB_roll_back_flag = 1;
        tick();
        ROB_roll_back_flag = 0;
        #1;
        chk("io_ready_after_rb", 32'(LSB_ready), 32'd1);
        chk("io_req_after_rb", 32'(MC_req_valid), 32'd0);
        tick();

        // Rollback while the load is in flight
        drive_op(OP_BASE + 2, 32'h500, 32'h0, 32'h0, 4'd9);
        tick();
        LSB_input_valid = 0;
        ROB_roll_back_flag = 1;
        tick();
        ROB_roll_back_flag = 0;
        tick();
        chk("sq_req_held", 32'(MC_req_valid), 32'd1);
        MC_done = 1; MC_rdata = 32'h11223344;
        tick();
        MC_done = 0;
        chk("sq_no_out", 32'(ROB_output_valid), 32'd0);
        chk("sq_req_drop", 32'(MC_req_valid), 32'd0);
        chk("sq_idle", 32'(LSB_ready), 32'd1);
        tick();

        // Async reset during an access
        drive_op(OP_BASE + 2, 32'h600, 32'h8, 32'h0, 4'd4);
        tick();
        LSB_input_valid = 0;
        tick();
        rst = 0;
        #1;
        chk("arst_req", 32'(MC_req_valid), 32'd0);
        chk("arst_ready", 32'(LSB_ready), 32'd1);
        model_reset();
        tick(); tick();
        rst = 1;
        drive_op(OP_BASE + 2, 32'h700, 32'h0, 32'h0, 4'd6);
        tick();
        LSB_input_valid = 0;
        MC_done = 1; MC_rdata = 32'hCAFEF00D;
        tick();
        MC_done = 0;
        chk("arst_after_vld", 32'(ROB_output_valid), 32'd1);
        chk("arst_after_val", ROB_output_value, 32'hCAFEF00D);
        chk("arst_after_id", 32'(ROB_output_id), 32'd6);
        tick();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 700 == 350) begin
                rst = 0; ROB_roll_back_flag = 0; LSB_input_valid = 0; MC_done = 0;
                model_reset();
                tick(); tick();
                rst = 1;
            end
            rdy             = ($urandom_range(0, 7) != 0);
            LSB_input_valid = $urandom_range(0, 1) == 1;
            LSB_OP_ID       = 6'($urandom_range(8, 19));
            LSB_reg_rs1     = $urandom;
            LSB_imm         = ($urandom_range(0, 3) == 0) ? $urandom
                                                          : 32'($urandom_range(0, 255)) - 32'd128;
            LSB_reg_rs2     = $urandom;
            LSB_ROB_id      = 4'($urandom);
            LSB_inst_pc     = $urandom;
            ROB_head_id     = ($urandom_range(0, 2) == 0) ? m_id : 4'($urandom);
            ROB_roll_back_flag = rdy && ($urandom_range(0, 15) == 0);
            MC_done         = m_req && rdy && ($urandom_range(0, 2) == 0);
            MC_rdata        = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ls_exec_unit.md
Name: ls_exec_unit

Overview:
- Execution stage directly downstream of the load/store buffer. Takes one issued memory op at a time, computes the effective address (rs1 + imm), runs the access over the memory-controller handshake, and broadcasts the result to the reorder buffer.
- Stores and IO-space loads are not speculative. They wait until their ROB id is at the ROB head.
- `ALU_ready` back to the buffer is this block's `LSB_ready`.

Parameters:
- OP_W, 6, width of op id bus.
- ROB_W, 4, width of ROB id.
- OP_BASE, 6'd10, op id of LB. The next seven consecutive ids are LH, LW, LBU, LHU, SB, SH, SW.
- IO_MASK, 2'b11, address bits [17:16] equal to this mark IO space.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; low = hold all state, outputs unchanged
- LSB_input_valid  in  1  op presented by LS buffer
- LSB_OP_ID  in  OP_W  op id
- LSB_inst_pc  in  32  pc (carried for debug only)
- LSB_reg_rs1  in  32  base register value
- LSB_reg_rs2  in  32  store data
- LSB_imm  in  32  sign-extended offset
- LSB_ROB_id  in  ROB_W  ROB tag
- LSB_ready  out  1  high = op will be accepted this cycle
- ROB_head_id  in  ROB_W  ROB id currently at commit head
- ROB_roll_back_flag  in  1  flush speculative work
- MC_req_valid  out  1  memory request, held until MC_done
- MC_is_write  out  1  1 = store
- MC_addr  out  32  byte address
- MC_wdata  out  32  store data, low bytes significant
- MC_size  out  2  0 = byte, 1 = half, 2 = word
- MC_done  in  1  one-cycle pulse: access finished
- MC_rdata  in  32  load data, zero-filled above size
- ROB_output_valid  out  1  one-cycle result broadcast
- ROB_output_id  out  ROB_W  tag of result
- ROB_output_value  out  32  load value (0 for stores)

Behaviour:
- Reset (rst low, any time, including mid-access): state=IDLE, squash=0. All outputs 0 except LSB_ready=1.
  - The memory controller is reset by the same rst, so no transaction survives reset.
- States: IDLE, WAIT_HEAD, MEM, BCAST.
- LSB_ready = (state==IDLE) && !ROB_roll_back_flag. It is combinational.
- IDLE, LSB_input_valid && LSB_ready:
  - Latch op, ROB id, rs2, size.
  - addr = rs1 + imm, mod 2^32, no misalignment check.
  - If store, or load with addr[17:16]==IO_MASK: go to WAIT_HEAD. Otherwise go to MEM.
  - Valid while not ready is ignored. The buffer does not pop in that case.
- WAIT_HEAD:
  - If ROB_roll_back_flag: go to IDLE, op dropped.
  - Else if ROB_head_id == latched id: go to MEM. The check is made in the same cycle as the comparison.
- MEM:
  - MC_req_valid=1. Address, data, size and is_write are stable for the whole request.
  - On MC_done: MC_req_valid drops the same edge.
  - Load result is extracted from MC_rdata:
    - LB: sign-extend [7:0]; LBU: zero-extend [7:0].
    - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
    - LW: all 32 bits.
  - Next state is BCAST. If squash==1, go to IDLE instead and clear squash.
  - ROB_roll_back_flag while in MEM sets squash=1 and the access completes normally. Stores in MEM are already at head; squash only suppresses the broadcast.
  - Rollback and MC_done in the same cycle: treated as squashed.
- BCAST:
  - ROB_output_valid=1 for exactly one cycle, with ROB_output_id and ROB_output_value. Then go to IDLE.
  - Rollback in BCAST: suppress valid, go to IDLE.
- Latency, non-IO load:
  - Accept at edge N; MC_req_valid high from N+1.
  - MC_done at edge M gives ROB_output_valid during cycle M+1.
  - Next accept possible at edge M+2.
- rdy low: freeze state and outputs. MC_done arriving while rdy is low is not guaranteed to be captured; the memory controller holds off while rdy is low.
- Undefined op ids inside the 8-op window cannot occur. An op outside the window is treated as LW.

Test Plan:
- LW, rs1=0x100, imm=0x4, MC_rdata=0xDEADBEEF, done after 3 cycles -> MC_addr=0x104, MC_size=2, MC_is_write=0; ROB_output_value=0xDEADBEEF, one-cycle valid, correct id.
- LB then LBU, rdata=0x00000080 -> values 0xFFFFFF80 and 0x00000080.
- SH, id=5, rs2=0x1234ABCD, ROB_head_id=3 for 4 cycles then 5 -> MC_req_valid only after head==5; MC_wdata=0x1234ABCD, MC_size=1; broadcast value 0.
- LW to 0x00030004 (IO) with head mismatch, then rollback -> no MC request, back to IDLE, LSB_ready=1 next cycle.
- LW in MEM, rollback asserted, MC_done two cycles later -> request completes, no ROB_output_valid, IDLE after done.
- rst pulled low during MEM -> MC_req_valid=0 and LSB_ready=1 immediately (async); after release a new LW completes normally.
